i2s_tx_fifo: RTL and testbench
==============================

I2S_TX_FIFO -- requirements
Module: i2s_tx_fifo

Interface
REQ-001 SHALL have parameter SAMPLE_W, default 16, bits per channel sample; legal range 8..31.
REQ-002 SHALL have parameter FIFO_DEPTH, default 8, number of stereo frames buffered; power of 2, minimum 2.
REQ-003 SHALL have parameter BCK_DIV, default 4, in_clk cycles per bck half-period; minimum 1.
REQ-004 SHALL have parameter REQ_LEVEL, default 2, FIFO level below which a request is raised.
REQ-005 SHALL have port in_clk, input, 1, sole clock; all logic on its rising edge.
REQ-006 SHALL have port rst, input, 1, reset; synchronous, active-high.
REQ-007 SHALL have port in_valid, input, 1, frame write strobe.
REQ-008 SHALL have port in_ready, output, 1, FIFO not full.
REQ-009 SHALL have port in_data, input, 2*SAMPLE_W, stereo frame; left in upper half, right in lower half.
REQ-010 SHALL have port rate_mode, input, 2: 00 = 44.1k (R=1), 01 = 22.05k (R=2), 10 = 11.025k (R=4), 11 = treated as 00.
REQ-011 SHALL have port enable, input, 1, playback enable.
REQ-012 SHALL have port audio_req_tick, output, 1, one-cycle sample request pulse.
REQ-013 SHALL have port fifo_level, output, $clog2(FIFO_DEPTH)+1, current occupancy.
REQ-014 SHALL have port underrun, output, 1, one-cycle pulse per underrun frame.
REQ-015 SHALL have ports bck, lrck and sout, each output, 1: bit clock, word clock (0 = left), serial data.

Function
REQ-016 SHALL divide in_clk by a counter 0..BCK_DIV-1; bck toggles when the counter equals BCK_DIV-1, and the counter then returns to 0.
REQ-017 SHALL define the fall strobe as the cycle in which bck toggles 1->0; bitcnt (6 bits, 0..63) advances on each fall strobe, wrapping 63->0.
REQ-018 SHALL register lrck = bitcnt[5], so lrck changes only on fall strobes.
REQ-019 SHALL drive the slot MSB first at slot positions 1..SAMPLE_W (bitcnt[4:0]) and drive 0 at position 0 and at positions above SAMPLE_W (I2S, one-bck delay); sout changes only on fall strobes.
REQ-020 SHALL treat the fall strobe at which bitcnt becomes 0 as the frame boundary.
REQ-021 SHALL apply this priority at each frame boundary: if enable=0, hold a zero frame with no pop.
REQ-022 SHALL otherwise, if repeat count > 0, decrement it and reuse the held frame.
REQ-023 SHALL otherwise, if the FIFO is non-empty, pop the head frame into the held frame and load repeat count = R-1, with R taken from rate_mode at that boundary.
REQ-024 SHALL otherwise signal underrun (REQ-027) and hold a zero frame.
REQ-025 SHALL take the left slot from the held frame at bitcnt 0 and the right slot from the same held frame at bitcnt 32; a frame is never split across two FIFO entries.
REQ-026 SHALL pulse audio_req_tick for one cycle at the frame boundary when enable=1, no repeat is pending after that boundary, and the post-pop level < REQ_LEVEL.
REQ-027 SHALL pulse underrun for one cycle at the underrun boundary.
REQ-028 SHALL write the FIFO when in_valid && in_ready; in_ready = (level != FIFO_DEPTH), registered from the current level.
REQ-029 SHALL ignore writes while full, with no overwrite.
REQ-030 SHALL, on a write and a pop in the same cycle, leave the level unchanged and keep data order.
REQ-031 SHALL evaluate a pop from the empty/full state before the same-cycle write, so a write to an empty FIFO at a boundary cycle is an underrun.
REQ-032 SHALL wrap FIFO pointers modulo FIFO_DEPTH; fifo_level SHALL be exact from 0 to FIFO_DEPTH.
REQ-033 SHALL let an enable change take effect only at the next frame boundary; a deasserting enable SHALL complete the current frame.

Reset
REQ-034 SHALL, while rst=1, force bck=0, lrck=0, sout=0, bitcnt=0, divider=0, repeat count=0, held frame=0, FIFO empty, in_ready=1, fifo_level=0, audio_req_tick=0, underrun=0.
REQ-035 SHALL, when reset is asserted mid-frame, discard FIFO contents and the partially sent frame; the first bck rise occurs BCK_DIV cycles after rst falls.

Configuration
REQ-036 SHALL, with macro I2S_TX_UNDERRUN_REPEAT_EN defined, replay the last held frame on an underrun frame instead of zeros; underrun still pulses, and after reset the replayed frame is zero.
REQ-037 SHALL, without I2S_TX_UNDERRUN_REPEAT_EN, output zeros on an underrun frame.

Verification (SAMPLE_W=16, FIFO_DEPTH=8, BCK_DIV=2, REQ_LEVEL=2)
REQ-038 SHALL check reset: assert rst for 3 cycles -> all REQ-034 values; first bck rise 2 cycles after release; lrck period 256 in_clk cycles.
REQ-039 SHALL check one frame: write 0xA5A5_5A5A, enable=1, rate 00 -> next frame shows left bits 1..16 = A5A5, right bits 33..48 = 5A5A, zeros elsewhere; audio_req_tick at that boundary.
REQ-040 SHALL check 22k mode: write 0x1111_2222 and 0x3333_4444, rate 01 -> each frame is output exactly twice in order; audio_req_tick only on boundaries with no pending repeat.
REQ-041 SHALL check full FIFO: 9 back-to-back writes while enable=0 -> fifo_level=8, in_ready=0 after the 8th write; the 9th frame is never output.
REQ-042 SHALL check underrun: play one frame, then keep the FIFO empty -> underrun pulses each frame; sout is 0 without the macro and repeats the last frame with I2S_TX_UNDERRUN_REPEAT_EN.
REQ-043 SHALL check reset mid-frame: assert rst at bitcnt 20 with 3 frames queued -> FIFO empty, output silent, and the next written frame starts at a fresh left slot.

Source files
------------

// File: rtl/i2s_tx_fifo.sv
// I2S transmitter fed by a stereo-frame FIFO, with sample-rate repeat and underrun signalling.
// Optional build macro I2S_TX_UNDERRUN_REPEAT_EN: replay the last held frame on underrun instead of silence.
module i2s_tx_fifo #(
    parameter int SAMPLE_W   = 16,
    parameter int FIFO_DEPTH = 8,
    parameter int BCK_DIV    = 4,
    parameter int REQ_LEVEL  = 2
) (
    input  logic                        in_clk,
    input  logic                        rst,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [2*SAMPLE_W-1:0]       in_data,
    input  logic [1:0]                  rate_mode,
    input  logic                        enable,
    output logic                        audio_req_tick,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level,
    output logic                        underrun,
    output logic                        bck,
    output logic                        lrck,
    output logic                        sout
);
    localparam int FW = 2 * SAMPLE_W;
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int LW = PW + 1;
    localparam int DW = (BCK_DIV > 1) ? $clog2(BCK_DIV) : 1;
    localparam logic [DW-1:0] DIV_MAX  = DW'(BCK_DIV - 1);
    localparam logic [DW-1:0] DIV_ONE  = DW'(1'b1);
    localparam logic [LW-1:0] LVL_ONE  = LW'(1'b1);
    localparam logic [LW-1:0] FULL_LVL = LW'(FIFO_DEPTH);
    localparam logic [LW-1:0] REQ_LVL  = LW'(REQ_LEVEL);
    localparam logic [PW-1:0] PTR_ONE  = PW'(1'b1);

    // Extra plays of each popped frame: R-1 for R = 1, 2, 4.
    function automatic logic [1:0] rate_repeat(input logic [1:0] mode);
        logic [1:0] rep;
        case (mode)
            2'b01:   rep = 2'd1;
            2'b10:   rep = 2'd3;
            default: rep = 2'd0;
        endcase
        return rep;
    endfunction

    // Serial bit for slot position pos: MSB at position 1, zero at position 0 and past the sample.
    function automatic logic slot_bit(input logic [FW-1:0] frame, input logic [5:0] pos);
        logic [SAMPLE_W-1:0] sample;
        logic                b;
        sample = pos[5] ? frame[SAMPLE_W-1:0] : frame[FW-1:SAMPLE_W];
        b = 1'b0;
        for (int i = 0; i < SAMPLE_W; i++) begin
            if (pos[4:0] == 5'(SAMPLE_W - i)) begin
                b = sample[i];
            end
        end
        return b;
    endfunction

    logic [DW-1:0] div_cnt_r;
    logic          bck_r;
    logic [5:0]    bitcnt_r;
    logic          lrck_r;
    logic          sout_r;
    logic [FW-1:0] held_r;
    logic [1:0]    rep_r;
    logic [FW-1:0] mem_r [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_r;
    logic [PW-1:0] rd_ptr_r;
    logic [LW-1:0] level_r;
    logic          in_ready_r;
    logic          req_r;
    logic          underrun_r;

    logic          fall_s;
    logic          boundary_s;
    logic [5:0]    bitcnt_nxt_s;
    logic          push_s;
    logic          pop_s;
    logic          underrun_s;
    logic          req_s;
    logic [FW-1:0] held_nxt_s;
    logic [1:0]    rep_nxt_s;
    logic [LW-1:0] level_post_pop_s;
    logic [LW-1:0] level_nxt_s;

    // Frame-boundary decision: disabled, repeat, pop or underrun; pop is judged on the pre-write level.
    always_comb begin
        fall_s       = bck_r && (div_cnt_r == DIV_MAX);
        boundary_s   = fall_s && (bitcnt_r == 6'd63);
        bitcnt_nxt_s = bitcnt_r + 6'd1;
        push_s       = in_valid && in_ready_r;
        pop_s        = 1'b0;
        underrun_s   = 1'b0;
        held_nxt_s   = held_r;
        rep_nxt_s    = rep_r;
        if (boundary_s) begin
            if (!enable) begin
                held_nxt_s = '0;
                rep_nxt_s  = 2'd0;
            end else if (rep_r != 2'd0) begin
                rep_nxt_s = rep_r - 2'd1;
            end else if (level_r != '0) begin
                pop_s      = 1'b1;
                held_nxt_s = mem_r[rd_ptr_r];
                rep_nxt_s  = rate_repeat(rate_mode);
            end else begin
                underrun_s = 1'b1;
`ifdef I2S_TX_UNDERRUN_REPEAT_EN
                held_nxt_s = held_r;
`else
                held_nxt_s = '0;
`endif
            end
        end else begin
            held_nxt_s = held_r;
        end
        level_post_pop_s = pop_s ? (level_r - LVL_ONE) : level_r;
        level_nxt_s      = push_s ? (level_post_pop_s + LVL_ONE) : level_post_pop_s;
        req_s            = boundary_s && enable && (rep_nxt_s == 2'd0) && (level_post_pop_s < REQ_LVL);
    end

    // Clock divider, serializer, frame holding and FIFO bookkeeping.
    always_ff @(posedge in_clk) begin
        if (rst) begin
            div_cnt_r  <= '0;
            bck_r      <= 1'b0;
            bitcnt_r   <= 6'd0;
            lrck_r     <= 1'b0;
            sout_r     <= 1'b0;
            held_r     <= '0;
            rep_r      <= 2'd0;
            wr_ptr_r   <= '0;
            rd_ptr_r   <= '0;
            level_r    <= '0;
            in_ready_r <= 1'b1;
            req_r      <= 1'b0;
            underrun_r <= 1'b0;
        end else begin
            if (div_cnt_r == DIV_MAX) begin
                div_cnt_r <= '0;
                bck_r     <= ~bck_r;
            end else begin
                div_cnt_r <= div_cnt_r + DIV_ONE;
            end
            if (fall_s) begin
                bitcnt_r <= bitcnt_nxt_s;
                lrck_r   <= bitcnt_nxt_s[5];
                sout_r   <= slot_bit(held_nxt_s, bitcnt_nxt_s);
            end
            held_r <= held_nxt_s;
            rep_r  <= rep_nxt_s;
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            level_r    <= level_nxt_s;
            in_ready_r <= (level_nxt_s != FULL_LVL);
            req_r      <= req_s;
            underrun_r <= underrun_s;
        end
    end

    // FIFO storage; contents are meaningless until pointed to, so no reset is needed.
    always_ff @(posedge in_clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= in_data;
        end
    end

    assign in_ready       = in_ready_r;
    assign fifo_level     = level_r;
    assign audio_req_tick = req_r;
    assign underrun       = underrun_r;
    assign bck            = bck_r;
    assign lrck           = lrck_r;
    assign sout           = sout_r;
endmodule

// File: tb/tb_i2s_tx_fifo.sv
// Self-checking bench for i2s_tx_fifo: a monitor decodes each I2S frame into a queue,
// tests push expected frames and compare them in order.
module tb_i2s_tx_fifo;
    typedef struct packed {
        logic [63:0] bits;
        logic        tick;
        logic        urun;
    } frame_t;

    logic        in_clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [31:0] in_data = 32'h0;
    logic [1:0]  rate_mode = 2'b00;
    logic        enable = 1'b0;
    logic        in_ready;
    logic        audio_req_tick;
    logic [3:0]  fifo_level;
    logic        underrun;
    logic        bck;
    logic        lrck;
    logic        sout;

    int errors = 0;
    int checks = 0;
    int lrck_bad = 0;
    int stray_cnt = 0;

    logic [5:0]  bpos = 6'd0;
    logic        prev_bck = 1'b0;
    logic [63:0] cur = 64'h0;
    logic        cur_tick = 1'b0;
    logic        cur_urun = 1'b0;
    frame_t      obs_q[$];
    frame_t      exp_q[$];

    i2s_tx_fifo #(.SAMPLE_W(16), .FIFO_DEPTH(8), .BCK_DIV(2), .REQ_LEVEL(2)) dut (
        .in_clk(in_clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .rate_mode(rate_mode), .enable(enable),
        .audio_req_tick(audio_req_tick), .fifo_level(fifo_level), .underrun(underrun),
        .bck(bck), .lrck(lrck), .sout(sout)
    );

    always #5 in_clk = ~in_clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    // Monitor: follows bck falls, records the sout bit at every slot position and the boundary pulses.
    initial begin
        forever begin
            @(negedge in_clk);
            if (rst) begin
                bpos = 6'd0; prev_bck = 1'b0; cur = 64'h0; cur_tick = 1'b0; cur_urun = 1'b0;
            end else begin
                if ((audio_req_tick || underrun) && !(prev_bck && !bck && bpos == 6'd63))
                    stray_cnt++;
                if (prev_bck && !bck) begin
                    bpos = bpos + 6'd1;
                    if (lrck !== bpos[5]) lrck_bad++;
                    if (bpos == 6'd0) begin
                        cur = 64'h0; cur_tick = audio_req_tick; cur_urun = underrun;
                    end
                    cur[bpos] = sout;
                    if (bpos == 6'd63) obs_q.push_back({cur, cur_tick, cur_urun});
                end
                prev_bck = bck;
            end
        end
    end

    function automatic frame_t mk(input logic [31:0] d, input logic tick, input logic urun);
        frame_t f;
        f.bits = 64'h0;
        for (int p = 1; p <= 16; p++) begin
            f.bits[p]      = d[32-p];
            f.bits[32+p]   = d[16-p];
        end
        f.tick = tick;
        f.urun = urun;
        return f;
    endfunction

    function automatic logic [31:0] ur(input logic [31:0] last);
        logic [31:0] r;
        r = last;
`ifndef I2S_TX_UNDERRUN_REPEAT_EN
        r = 32'h0;
`endif
        return r;
    endfunction

    task automatic do_reset(input logic en, input logic [1:0] rate);
        @(posedge in_clk); #1;
        rst = 1'b1; in_valid = 1'b0; enable = en; rate_mode = rate;
        repeat (3) @(posedge in_clk);
        #1;
        rst = 1'b0;
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic write_frame(input logic [31:0] d);
        in_valid = 1'b1; in_data = d;
        @(posedge in_clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_obs(input int n, output logic ok);
        ok = 1'b0;
        for (int c = 0; c < (n + 1) * 300 && !ok; c++) begin
            if (obs_q.size() >= n) ok = 1'b1;
            else begin @(posedge in_clk); #1; end
        end
    endtask

    task automatic test_reset();
        int c; logic seen; int t1; int t2; logic prev;
        rst = 1'b1; in_valid = 1'b0; enable = 1'b0;
        repeat (3) @(posedge in_clk);
        #1;
        checks++;
        if ({bck, lrck, sout, in_ready, fifo_level, audio_req_tick, underrun} !== 10'b0001_0000_00) begin
            errors++;
            $display("FAIL reset_state: got %b expected 0001000000",
                     {bck, lrck, sout, in_ready, fifo_level, audio_req_tick, underrun});
        end
        rst = 1'b0;
        c = 0; seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(posedge in_clk); #1;
            c++;
            if (bck) seen = 1'b1;
        end
        checks++;
        if (!seen || c != 2) begin
            errors++;
            $display("FAIL first_bck_rise: got %0d cycles (seen=%b) expected 2", c, seen);
        end
        t1 = -1; t2 = -1; prev = lrck;
        for (int i = 0; i < 1000 && t2 < 0; i++) begin
            @(posedge in_clk); #1;
            if (lrck && !prev) begin
                if (t1 < 0) t1 = i; else t2 = i;
            end
            prev = lrck;
        end
        checks++;
        if (t2 < 0 || (t2 - t1) != 256) begin
            errors++;
            $display("FAIL lrck_period: got %0d expected 256", t2 - t1);
        end
    endtask

    task automatic test_one_frame();
        logic ok; frame_t o; frame_t e;
        do_reset(1'b1, 2'b00);
        write_frame(32'hA5A5_5A5A);
        exp_q.push_back(mk(32'h0, 1'b0, 1'b0));
        exp_q.push_back(mk(32'hA5A5_5A5A, 1'b1, 1'b0));
        exp_q.push_back(mk(ur(32'hA5A5_5A5A), 1'b1, 1'b1));
        exp_q.push_back(mk(ur(32'hA5A5_5A5A), 1'b1, 1'b1));
        checks++;
        if (fifo_level !== 4'd1 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL one_frame_level: got level=%0d ready=%b expected level=1 ready=1", fifo_level, in_ready);
        end
        wait_obs(4, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL one_frame_timeout: got %0d frames expected 4", obs_q.size()); end
        for (int i = 0; ok && i < 4; i++) begin
            o = obs_q.pop_front(); e = exp_q.pop_front();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL one_frame[%0d]: got bits=%h tick=%b urun=%b expected bits=%h tick=%b urun=%b",
                         i, o.bits, o.tick, o.urun, e.bits, e.tick, e.urun);
            end
        end
    endtask

    task automatic test_rate_22k();
        logic ok; frame_t o; frame_t e;
        do_reset(1'b1, 2'b01);
        write_frame(32'h1111_2222);
        write_frame(32'h3333_4444);
        exp_q.push_back(mk(32'h0, 1'b0, 1'b0));
        exp_q.push_back(mk(32'h1111_2222, 1'b0, 1'b0));
        exp_q.push_back(mk(32'h1111_2222, 1'b1, 1'b0));
        exp_q.push_back(mk(32'h3333_4444, 1'b0, 1'b0));
        exp_q.push_back(mk(32'h3333_4444, 1'b1, 1'b0));
        exp_q.push_back(mk(ur(32'h3333_4444), 1'b1, 1'b1));
        checks++;
        if (fifo_level !== 4'd2) begin
            errors++;
            $display("FAIL rate22k_level: got %0d expected 2", fifo_level);
        end
        wait_obs(6, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL rate22k_timeout: got %0d frames expected 6", obs_q.size()); end
        for (int i = 0; ok && i < 6; i++) begin
            o = obs_q.pop_front(); e = exp_q.pop_front();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL rate22k[%0d]: got bits=%h tick=%b urun=%b expected bits=%h tick=%b urun=%b",
                         i, o.bits, o.tick, o.urun, e.bits, e.tick, e.urun);
            end
        end
    endtask

    task automatic test_full();
        logic ok; frame_t o; frame_t e; logic [31:0] d;
        do_reset(1'b0, 2'b00);
        for (int i = 0; i < 9; i++) begin
            d = 32'h1000_2000 + (32'h0001_0001 * 32'(i));
            write_frame(d);
            if (i == 7) begin
                checks++;
                if (fifo_level !== 4'd8 || in_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL full_after8: got level=%0d ready=%b expected level=8 ready=0", fifo_level, in_ready);
                end
            end
        end
        for (int f = 0; f < 3; f++) exp_q.push_back(mk(32'h0, 1'b0, 1'b0));
        for (int k = 0; k < 8; k++) begin
            d = 32'h1000_2000 + (32'h0001_0001 * 32'(k));
            exp_q.push_back(mk(d, (k >= 6) ? 1'b1 : 1'b0, 1'b0));
        end
        exp_q.push_back(mk(ur(32'h1007_2007), 1'b1, 1'b1));
        wait_obs(2, ok);
        repeat (40) @(posedge in_clk);
        #1;
        checks++;
        if (fifo_level !== 4'd8 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL full_disabled_hold: got level=%0d ready=%b expected level=8 ready=0", fifo_level, in_ready);
        end
        enable = 1'b1;
        wait_obs(12, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL full_timeout: got %0d frames expected 12", obs_q.size()); end
        for (int i = 0; ok && i < 12; i++) begin
            o = obs_q.pop_front(); e = exp_q.pop_front();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL full[%0d]: got bits=%h tick=%b urun=%b expected bits=%h tick=%b urun=%b",
                         i, o.bits, o.tick, o.urun, e.bits, e.tick, e.urun);
            end
        end
    endtask

    task automatic test_midreset();
        logic ok; logic hit; frame_t o; frame_t e;
        do_reset(1'b1, 2'b00);
        for (int i = 0; i < 4; i++) write_frame(32'hC0DE_0000 + 32'(i));
        wait_obs(1, ok);
        hit = 1'b0;
        for (int c = 0; c < 300 && !hit; c++) begin
            if (bpos == 6'd20) hit = 1'b1;
            else begin @(posedge in_clk); #1; end
        end
        checks++;
        if (!hit || fifo_level !== 4'd3) begin
            errors++;
            $display("FAIL midreset_pre: got reached=%b level=%0d expected reached=1 level=3", hit, fifo_level);
        end
        rst = 1'b1;
        repeat (3) @(posedge in_clk);
        #1;
        checks++;
        if ({bck, lrck, sout, in_ready, fifo_level, audio_req_tick, underrun} !== 10'b0001_0000_00) begin
            errors++;
            $display("FAIL midreset_state: got %b expected 0001000000",
                     {bck, lrck, sout, in_ready, fifo_level, audio_req_tick, underrun});
        end
        rst = 1'b0;
        obs_q.delete();
        exp_q.delete();
        rate_mode = 2'b11;
        write_frame(32'hBEEF_CAFE);
        exp_q.push_back(mk(32'h0, 1'b0, 1'b0));
        exp_q.push_back(mk(32'hBEEF_CAFE, 1'b1, 1'b0));
        exp_q.push_back(mk(ur(32'hBEEF_CAFE), 1'b1, 1'b1));
        wait_obs(3, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL midreset_timeout: got %0d frames expected 3", obs_q.size()); end
        for (int i = 0; ok && i < 3; i++) begin
            o = obs_q.pop_front(); e = exp_q.pop_front();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL midreset[%0d]: got bits=%h tick=%b urun=%b expected bits=%h tick=%b urun=%b",
                         i, o.bits, o.tick, o.urun, e.bits, e.tick, e.urun);
            end
        end
    endtask

    task automatic test_integrity();
        checks++;
        if (lrck_bad != 0) begin
            errors++;
            $display("FAIL lrck_alignment: got %0d misaligned bits expected 0", lrck_bad);
        end
        checks++;
        if (stray_cnt != 0) begin
            errors++;
            $display("FAIL stray_pulses: got %0d off-boundary pulses expected 0", stray_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_one_frame();
        test_rate_22k();
        test_full();
        test_midreset();
        test_integrity();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
